// File: rtl/demux_1_4_32_buf.sv
// ----------------------------------------------------------------------------
// demux_1_4_32_buf
//   Routes a 32-bit word to one of four output channels. Each channel has a
//   one-entry output register with valid/ready handshaking. A channel can
//   accept a new word in the same cycle that its current word is delivered,
//   so each channel sustains one word per cycle. A stalled channel blocks
//   only transfers aimed at itself.
//
// Ports
//   clk            : clock, all state updates on the rising edge
//   rst_n          : synchronous active-low reset
//   din[31:0]      : data word to route
//   sel[1:0]       : destination channel for din
//   in_valid       : din/sel valid this cycle
//   in_ready       : block accepts din this cycle (combinational)
//   res0..res3     : per-channel registered data
//   out_valid[3:0] : bit k set while resk holds an undelivered word
//   out_ready[3:0] : bit k set when the channel k consumer takes resk
//   cnt0..cnt3     : per-channel delivered-word counters (8-bit, wrapping)
//
// Configuration
//   DEMUX_CNT_EN   : when defined, adds the cnt0..cnt3 ports and counters.
//                    When undefined, those ports and their logic are absent.
// ----------------------------------------------------------------------------

// One output channel: a single data register plus its valid flag.
module demux_1_4_32_buf_lane #(
    parameter int VEC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,   // transfer targeting this channel
    input  logic [VEC_W-1:0] din_i,
    input  logic             ready_i,  // consumer takes the word this cycle
    output logic [VEC_W-1:0] data_o,
    output logic             valid_o
);
    logic [VEC_W-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // A load wins over a delivery: it replaces the outgoing word and keeps
    // valid high, giving back-to-back throughput. Without a load, valid
    // drops only when the consumer takes the word; data is always held.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load_i) begin
            data_d  = din_i;
            valid_d = 1'b1;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
endmodule

module demux_1_4_32_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] din,
    input  logic [1:0]  sel,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] res0,
    output logic [31:0] res1,
    output logic [31:0] res2,
    output logic [31:0] res3,
    output logic [3:0]  out_valid,
    input  logic [3:0]  out_ready
`ifdef DEMUX_CNT_EN
    ,
    output logic [7:0]  cnt0,
    output logic [7:0]  cnt1,
    output logic [7:0]  cnt2,
    output logic [7:0]  cnt3
`endif
);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 32;

    logic [NUM_LANES-1:0][VEC_W-1:0] res;
    logic [NUM_LANES-1:0]            load;

    // Readiness depends only on the channel currently addressed, so a full
    // channel never stalls traffic to the others. Reset does not gate it;
    // any transfer during reset is discarded by the lane reset itself.
    assign in_ready = !out_valid[sel] || out_ready[sel];

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_load
        assign load[g] = in_valid && in_ready && (sel == 2'(g));
    end

    demux_1_4_32_buf_lane #(.VEC_W(VEC_W)) u_lane [NUM_LANES-1:0] (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .din_i   (din),
        .ready_i (out_ready),
        .data_o  (res),
        .valid_o (out_valid)
    );

    assign res0 = res[0];
    assign res1 = res[1];
    assign res2 = res[2];
    assign res3 = res[3];

`ifdef DEMUX_CNT_EN
    logic [NUM_LANES-1:0][7:0] cnt_q, cnt_d;
    logic [NUM_LANES-1:0]      deliv;

    assign deliv = out_valid & out_ready;

    // 8-bit counters wrap naturally from FF to 00.
    always_comb begin
        cnt_d = cnt_q;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (deliv[k]) cnt_d[k] = cnt_q[k] + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];
`endif
endmodule

// File: tb/tb_demux_1_4_32_buf.sv
// ----------------------------------------------------------------------------
// tb_demux_1_4_32_buf
//   Scoreboard bench. A model process samples the DUT inputs on every rising
//   edge and keeps, per channel, a queue of words accepted but not yet
//   delivered, the last delivered word and a delivery count. A monitor on the
//   falling edge compares out_valid, in_ready, res0..3 (and cnt0..3 when
//   DEMUX_CNT_EN is defined) against that model. Directed sequences plus a
//   randomized phase supply the stimulus.
// ----------------------------------------------------------------------------
module tb_demux_1_4_32_buf;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] din;
    logic [1:0]  sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] res0, res1, res2, res3;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
`ifdef DEMUX_CNT_EN
    logic [7:0]  cnt0, cnt1, cnt2, cnt3;
`endif

    demux_1_4_32_buf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .res0      (res0),
        .res1      (res1),
        .res2      (res2),
        .res3      (res3),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX_CNT_EN
        ,
        .cnt0      (cnt0),
        .cnt1      (cnt1),
        .cnt2      (cnt2),
        .cnt3      (cnt3)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] expq [4][$];  // accepted, not yet delivered
    logic [31:0] last_m [4];   // value res should hold when channel is empty
    int          cnt_m [4];
    bit          armed = 1'b0;

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                expq[k].delete();
                last_m[k] = '0;
                cnt_m[k]  = 0;
            end
            armed = 1'b1;
        end else if (armed) begin
            bit rdy;
            rdy = (expq[sel].size() == 0) || out_ready[sel];
            for (int k = 0; k < 4; k++) begin
                if (expq[k].size() != 0 && out_ready[k]) begin
                    last_m[k] = expq[k].pop_front();
                    cnt_m[k]  = (cnt_m[k] + 1) % 256;
                end
            end
            if (in_valid && rdy) expq[sel].push_back(din);
        end
    end

    // ---------------- monitor ----------------
    logic [31:0] resv [4];
    assign resv[0] = res0;
    assign resv[1] = res1;
    assign resv[2] = res2;
    assign resv[3] = res3;

    initial forever begin
        @(negedge clk);
        if (armed) begin
            logic [3:0] ov_m;
            for (int k = 0; k < 4; k++) ov_m[k] = (expq[k].size() != 0);
            chk("mon out_valid", {28'd0, out_valid}, {28'd0, ov_m});
            chk("mon in_ready", {31'd0, in_ready}, {31'd0, (!ov_m[sel] || out_ready[sel])});
            for (int k = 0; k < 4; k++) begin
                if (ov_m[k]) chk($sformatf("mon res%0d pending", k), resv[k], expq[k][0]);
                else         chk($sformatf("mon res%0d held", k), resv[k], last_m[k]);
            end
`ifdef DEMUX_CNT_EN
            chk("mon cnt0", {24'd0, cnt0}, 32'(cnt_m[0]));
            chk("mon cnt1", {24'd0, cnt1}, 32'(cnt_m[1]));
            chk("mon cnt2", {24'd0, cnt2}, 32'(cnt_m[2]));
            chk("mon cnt3", {24'd0, cnt3}, 32'(cnt_m[3]));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // reset with a transfer presented: must be discarded
        rst_n = 1'b0; in_valid = 1'b1; din = 32'hDEADBEEF; sel = 2'b01; out_ready = 4'b0000;
        step(); step();
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        chk("reset out_valid", {28'd0, out_valid}, 32'h0);
        chk("reset res1", res1, 32'h0);
        chk("reset res0", res0, 32'h0);
        chk("reset res3", res3, 32'h0);

        // single route to ch2
        out_ready = 4'hF; din = 32'h12345678; sel = 2'b10; in_valid = 1'b1;
        step();
        in_valid = 1'b0; #1;
        chk("route out_valid", {28'd0, out_valid}, 32'h4);
        chk("route res2", res2, 32'h12345678);
        step(); #1;
        chk("route drained", {28'd0, out_valid}, 32'h0);
        chk("route res2 held", res2, 32'h12345678);

        // back-pressure on ch3
        out_ready = 4'b0111; sel = 2'b11; din = 32'hA5A5A5A5; in_valid = 1'b1;
        step();
        din = 32'h1; #1;
        chk("bp in_ready low", {31'd0, in_ready}, 32'h0);
        step(); #1;
        chk("bp res3 stable", res3, 32'hA5A5A5A5);
        chk("bp ch3 valid", {31'd0, out_valid[3]}, 32'h1);
        out_ready = 4'hF; #1;
        chk("bp in_ready high", {31'd0, in_ready}, 32'h1);
        step();
        in_valid = 1'b0; #1;
        chk("bp res3 new", res3, 32'h1);
        chk("bp ch3 still valid", {31'd0, out_valid[3]}, 32'h1);
        step();

        // independence: ch0 stalled and full, ch1 still accepts
        out_ready = 4'b1110; sel = 2'b00; din = 32'hAA; in_valid = 1'b1;
        step();
        sel = 2'b01; din = 32'h55; #1;
        chk("indep in_ready", {31'd0, in_ready}, 32'h1);
        step();
        in_valid = 1'b0; #1;
        chk("indep res1", res1, 32'h55);
        chk("indep res0", res0, 32'hAA);
        chk("indep out_valid", {28'd0, out_valid}, 32'h3);
        out_ready = 4'hF;
        step(); step();

        // streaming 8 words to ch0, one per cycle
        for (int i = 0; i < 8; i++) begin
            sel = 2'b00; din = 32'(100 + i); in_valid = 1'b1;
            step();
            chk($sformatf("stream valid %0d", i), {31'd0, out_valid[0]}, 32'h1);
            chk($sformatf("stream res0 %0d", i), res0, 32'(100 + i));
        end
        in_valid = 1'b0;
        step();
        chk("stream end valid", {31'd0, out_valid[0]}, 32'h0);
        chk("stream end res0", res0, 32'd107);

`ifdef DEMUX_CNT_EN
        // counter wrap on ch2
        rst_n = 1'b0; step(); rst_n = 1'b1;
        out_ready = 4'hF;
        for (int i = 0; i < 257; i++) begin
            sel = 2'b10; din = $urandom; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        step();
        chk("wrap cnt2", {24'd0, cnt2}, 32'h1);
        chk("wrap cnt0", {24'd0, cnt0}, 32'h0);
        chk("wrap cnt1", {24'd0, cnt1}, 32'h0);
        chk("wrap cnt3", {24'd0, cnt3}, 32'h0);
`endif

        // pending word dropped by reset
        out_ready = 4'b0000; sel = 2'b01; din = 32'hCAFE0001; in_valid = 1'b1;
        step();
        in_valid = 1'b0; rst_n = 1'b0;
        step();
        rst_n = 1'b1; #1;
        chk("drop out_valid", {28'd0, out_valid}, 32'h0);
        chk("drop res1", res1, 32'h0);

        // randomized traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            rst_n     = ($urandom_range(0, 80) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            sel       = 2'($urandom_range(0, 3));
            din       = $urandom;
            out_ready = 4'($urandom);
            step();
        end

        rst_n = 1'b1; in_valid = 1'b0; out_ready = 4'hF;
        step(); step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
